// File: rtl/rv_pc_pkg.sv
// Shared RISC32 PC definitions: default widths/vectors and the next-PC source select.
package rv_pc_pkg;
  localparam int          DEFAULT_XLEN         = 32;
  localparam int          DEFAULT_INSTR_BYTES  = 4;
  localparam int          DEFAULT_RAS_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_TGT,
    SEL_RAS,
    SEL_RETT,
    SEL_TRAP
  } pc_sel_e;
endpackage

// File: rtl/pc_unit_if.sv
// Control-to-PC bundle: redirect requests in, fetch address and RAS status out.
interface pc_unit_if #(parameter int XLEN = 32);
  logic            PCHold;
  logic            trap;
  logic            jump;
  logic            branch_taken;
  logic [XLEN-1:0] target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] ret_target;
  logic [XLEN-1:0] currentAddress;
  logic [XLEN-1:0] seqAddress;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;

  modport master (
    output PCHold, trap, jump, branch_taken, target, call, ret, ret_target,
    input  currentAddress, seqAddress, ras_empty, ras_full, misaligned
  );

  modport slave (
    input  PCHold, trap, jump, branch_taken, target, call, ret, ret_target,
    output currentAddress, seqAddress, ras_empty, ras_full, misaligned
  );
endinterface

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_q;
  logic [CW-1:0]   cnt_q;
  logic            do_pop;

  // A pop on an empty stack is a no-op so a simultaneous push still lands.
  assign do_pop   = pop && (cnt_q != '0);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign top_data = mem[top_q];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (do_pop && push) begin
      mem[top_q] <= push_data;
    end else if (push) begin
      top_q               <= top_q + PTR_ONE;
      mem[top_q + PTR_ONE] <= push_data;
      if (!full) cnt_q <= cnt_q + CNT_ONE;
    end else if (do_pop) begin
      top_q <= top_q - PTR_ONE;
      cnt_q <= cnt_q - CNT_ONE;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select mux, PC register, misaligned flag and RAS.
module pc_unit
  import rv_pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH,
  parameter int              INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
  input  logic     CLK,
  input  logic     RESET,
  pc_unit_if.slave bus
);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] seq_addr;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] ras_top;
  logic            redirect;
  logic            mis_d;
  logic            mis_q;
  logic            advance;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_empty;
  logic            ras_full;

  assign seq_addr = pc_q + XLEN'(INSTR_BYTES);
  assign advance  = bus.trap || !bus.PCHold;
  assign ras_push = bus.call && !bus.PCHold && !bus.trap;
  assign ras_pop  = bus.ret  && !bus.PCHold && !bus.trap;

  always_comb begin
    sel = SEL_SEQ;
    if (bus.trap)                          sel = SEL_TRAP;
    else if (bus.ret)                      sel = ras_empty ? SEL_RETT : SEL_RAS;
    else if (bus.jump || bus.branch_taken) sel = SEL_TGT;
  end

  always_comb begin
    raw_tgt = seq_addr;
    case (sel)
      SEL_TGT:  raw_tgt = bus.target;
      SEL_RAS:  raw_tgt = ras_top;
      SEL_RETT: raw_tgt = bus.ret_target;
      SEL_TRAP: raw_tgt = TRAP_VECTOR;
      default:  raw_tgt = seq_addr;
    endcase
  end

  // Only externally supplied targets get aligned and flagged; the trap vector is trusted.
  assign redirect = (sel == SEL_TGT) || (sel == SEL_RAS) || (sel == SEL_RETT);
  assign mis_d    = redirect && ((raw_tgt & LOW_MASK) != '0);
  assign next_pc  = redirect ? (raw_tgt & ~LOW_MASK) : raw_tgt;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else if (advance) begin
      pc_q  <= next_pc;
      mis_q <= mis_d;
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_addr),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.currentAddress = pc_q;
  assign bus.seqAddress     = seq_addr;
  assign bus.ras_empty      = ras_empty;
  assign bus.ras_full       = ras_full;
  assign bus.misaligned     = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random traffic against a queue-based PC/RAS model.
module tb_pc_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad = 0;

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: RAS as a bounded list, newest at the back.
  task automatic model_step();
    logic [31:0] seq, raw;
    bit          red;
    if (!RESET) begin
      m_pc = 32'h0;
      m_mis = 1'b0;
      m_ras.delete();
    end else if (bus.trap) begin
      m_pc = 32'h80;
      m_mis = 1'b0;
    end else if (!bus.PCHold) begin
      seq = m_pc + 32'd4;
      red = 1'b1;
      if (bus.ret) raw = (m_ras.size() > 0) ? m_ras.pop_back() : bus.ret_target;
      else if (bus.jump || bus.branch_taken) raw = bus.target;
      else begin
        raw = seq;
        red = 1'b0;
      end
      m_mis = red && (raw % 4 != 0);
      m_pc  = red ? raw - (raw % 4) : raw;
      if (bus.call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    chk("pc", bus.currentAddress, m_pc);
    chk("seq", bus.seqAddress, m_pc + 32'd4);
    chk("mis", {31'b0, bus.misaligned}, {31'b0, m_mis});
    chk("empty", {31'b0, bus.ras_empty}, {31'b0, m_ras.size() == 0});
    chk("full", {31'b0, bus.ras_full}, {31'b0, m_ras.size() == 4});
  endtask

  task automatic drive(input bit rst, input bit hold, input bit trp, input bit jmp, input bit br,
                       input bit cl, input bit rt, input logic [31:0] tgt, input logic [31:0] rtt);
    RESET = rst;
    bus.PCHold = hold;
    bus.trap = trp;
    bus.jump = jmp;
    bus.branch_taken = br;
    bus.call = cl;
    bus.ret = rt;
    bus.target = tgt;
    bus.ret_target = rtt;
    step();
  endtask

  task automatic seq_step();
    drive(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic jmp_to(input logic [31:0] t, input bit cl);
    drive(1, 0, 0, 1, 0, cl, 0, t, 32'h0);
  endtask

  task automatic ret_step(input logic [31:0] rtt);
    drive(1, 0, 0, 0, 0, 0, 1, 32'h0, rtt);
  endtask

  initial begin
    logic [31:0] tgt, rtt;
    m_pc = 32'h0;
    m_mis = 1'b0;

    // reset then sequential fetch
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_pc", bus.currentAddress, 32'h0);
    chk("rst_empty", {31'b0, bus.ras_empty}, 32'h1);
    seq_step(); chk("rst_seq4", bus.currentAddress, 32'h4);
    seq_step(); chk("rst_seq8", bus.currentAddress, 32'h8);
    seq_step(); chk("rst_seqc", bus.currentAddress, 32'hC);

    // hold vs trap
    jmp_to(32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 1, 1, 32'h300, 32'h0);
      chk("hold_pc", bus.currentAddress, 32'h10);
    end
    drive(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("trap_pc", bus.currentAddress, 32'h80);

    // call then return
    jmp_to(32'h40, 0);
    jmp_to(32'h200, 1);
    chk("call_pc", bus.currentAddress, 32'h200);
    seq_step(); seq_step();
    chk("pre_ret_pc", bus.currentAddress, 32'h208);
    ret_step(32'h0);
    chk("ret_pc", bus.currentAddress, 32'h44);
    chk("ret_empty", {31'b0, bus.ras_empty}, 32'h1);

    // overflow / underflow
    jmp_to(32'h0, 0);
    jmp_to(32'h100, 1); jmp_to(32'h200, 1); jmp_to(32'h300, 1);
    jmp_to(32'h400, 1); jmp_to(32'h500, 1);
    chk("ovf_full", {31'b0, bus.ras_full}, 32'h1);
    ret_step(32'h0); chk("ret1", bus.currentAddress, 32'h404);
    ret_step(32'h0); chk("ret2", bus.currentAddress, 32'h304);
    ret_step(32'h0); chk("ret3", bus.currentAddress, 32'h204);
    ret_step(32'h0); chk("ret4", bus.currentAddress, 32'h104);
    ret_step(32'h999);
    chk("ret5_pc", bus.currentAddress, 32'h998);
    chk("ret5_mis", {31'b0, bus.misaligned}, 32'h1);

    // simultaneous call and ret
    jmp_to(32'h10, 0);
    jmp_to(32'h50, 1);
    drive(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0);
    chk("cr_pc", bus.currentAddress, 32'h14);
    chk("cr_empty", {31'b0, bus.ras_empty}, 32'h0);
    ret_step(32'h0);
    chk("cr_top", bus.currentAddress, 32'h54);

    // wrap and reset during ret
    jmp_to(32'hFFFF_FFFC, 1);
    seq_step();
    chk("wrap_pc", bus.currentAddress, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h123);
    chk("rst_ret_pc", bus.currentAddress, 32'h0);
    chk("rst_ret_empty", {31'b0, bus.ras_empty}, 32'h1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      tgt = $urandom();
      rtt = $urandom();
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(3) != 0) rtt[1:0] = 2'b00;
      drive($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
            $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(3) == 0, tgt, rtt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
